shift_capture: RTL and testbench
================================

SHIFT_CAPTURE -- requirements
Module: shift_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 5: capture word width in bits, legal range 2..32.
REQ-002 SHALL have port clock, input, 1: single rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: begins (or restarts) a frame.
REQ-005 SHALL have port dir, input, 1: bit order, sampled only on an accepted start; 0 = MSB-first (shift left, new bit into bit 0), 1 = LSB-first (shift right, new bit into bit WIDTH-1).
REQ-006 SHALL have port sample_en, input, 1: bit strobe; sdata is accepted on clock edges where sample_en=1 in SHIFT.
REQ-007 SHALL have port sdata, input, 1: serial data bit.
REQ-008 SHALL have port ready, input, 1: consumer accepts data_out when valid=1.
REQ-009 SHALL have port clr_ovr, input, 1: clears overrun.
REQ-010 SHALL have port data_out, output, WIDTH: last completed word.
REQ-011 SHALL have port valid, output, 1: data_out holds an unconsumed word.
REQ-012 SHALL have port busy, output, 1: high while in SHIFT.
REQ-013 SHALL have port overrun, output, 1: sticky; a completed word was dropped.

Function
REQ-014 SHALL implement FSM states IDLE and SHIFT; IDLE --start--> SHIFT; SHIFT --last bit accepted--> IDLE; SHIFT --start--> SHIFT (restart).
REQ-015 On an accepted start, SHALL clear the shift register and bit counter to 0 and latch dir.
REQ-016 SHALL ignore sample_en on the start cycle; the first bit is taken on the next sample_en.
REQ-017 In SHIFT, each sample_en SHALL shift in sdata per latched dir and increment the counter; a mid-frame start SHALL take priority over sample_en.
REQ-018 When the WIDTH-th bit is accepted, SHALL, on that same edge, load data_out with the completed word (including that bit), return to IDLE, and form the completion event.
REQ-019 Completion latency SHALL be zero cycles: data_out/valid change on the edge accepting the final bit.
REQ-020 Handshake: valid SHALL be cleared on an edge with valid=1, ready=1 and no completion; data_out SHALL remain stable while valid=1 and ready=0.
REQ-021 Completion with valid=0, or with valid=1 and ready=1, SHALL load data_out and set valid=1, with no overrun.
REQ-022 Completion with valid=1 and ready=0 SHALL drop the new word, leave data_out unchanged, and set overrun=1.
REQ-023 overrun SHALL stay set until clr_ovr=1; if clr_ovr and a new overrun occur on the same edge, overrun SHALL remain 1.
REQ-024 busy SHALL equal (state == SHIFT); sample_en and sdata SHALL be ignored in IDLE.
REQ-025 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never exceed WIDTH.

Reset
REQ-026 reset=0 SHALL, asynchronously, force state IDLE, and clear the shift register, counter, latched dir, data_out, valid and overrun, all to 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial word; after reset release the block SHALL wait in IDLE for start.

Structure
REQ-028 A shared package shift_pkg SHALL hold the FSM state type (IDLE, SHIFT) and the constants DIR_MSB_FIRST=0 and DIR_LSB_FIRST=1.
REQ-029 The implementation SHALL be a single module with no sub-modules; the bit counter SHALL be inline.

Verification (WIDTH=5)
REQ-030 Test 1: start, dir=0, then bits 1,0,1,1,0 on five strobes -> data_out=5'b10110, valid=1 on the fifth strobe edge, busy=0.
REQ-031 Test 2: start, dir=1, then bits 1,0,1,1,0 -> data_out=5'b01101, valid=1.
REQ-032 Test 3: hold ready=0 after test 1, then complete a second frame of 0,0,0,0,1 -> overrun=1 and data_out stays 5'b10110; then clr_ovr=1 -> overrun=0.
REQ-033 Test 4: complete a frame on the same edge as ready=1 with valid=1 -> new word loaded, valid stays 1, overrun=0.
REQ-034 Test 5: after 3 of 5 bits, assert start, then send 1,1,0,0,1 with dir=0 -> data_out=5'b11001; the partial bits are not included.
REQ-035 Test 6: drive reset=0 mid-frame and between clock edges -> state, data_out, valid, overrun and busy go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shared state encoding and bit-order constants for shift_capture
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    // Frame sequencer states, kept as explicit-width constants for legacy users
    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t SHIFT = 1'b1;

    // Bit-order selector values for the dir input
    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage : shift_pkg

`default_nettype wire

// File: rtl/shift_capture.sv
// ============================================================================
// Module      : shift_capture
// Description : Serial-to-parallel word capture with valid/ready output and
//               sticky overrun flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_capture
    import shift_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic             sample_en,
    input  logic             sdata,
    input  logic             ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);

    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_dir;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic               r_ovr;

    logic               w_accept;
    logic               w_done;
    logic               w_drop;
    logic [WIDTH-1:0]   w_next_shift;

    // A start on the same edge always wins over the bit strobe
    assign w_accept = (r_state == SHIFT) && sample_en && !start;
    assign w_done   = w_accept && (r_cnt == c_LAST);
    assign w_drop   = w_done && r_valid && !ready;

    always_comb begin
        w_next_shift = r_shift;
        if (r_dir == DIR_LSB_FIRST) begin
            w_next_shift = {sdata, r_shift[WIDTH-1:1]};
        end else begin
            w_next_shift = {r_shift[WIDTH-2:0], sdata};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_dir   <= DIR_MSB_FIRST;
        end else if (start) begin
            r_state <= SHIFT;
            r_shift <= '0;
            r_cnt   <= '0;
            r_dir   <= dir;
        end else if (w_accept) begin
            r_shift <= w_next_shift;
            if (w_done) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + c_ONE;
            end
        end
    end

    // Output word register: a completion only overwrites a consumed or
    // simultaneously-consumed word; otherwise the new word is dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_done && (!r_valid || ready)) begin
            r_data  <= w_next_shift;
            r_valid <= 1'b1;
        end else if (r_valid && ready && !w_done) begin
            r_valid <= 1'b0;
        end
    end

    // A new drop beats a same-edge clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ovr <= 1'b0;
        end else if (w_drop) begin
            r_ovr <= 1'b1;
        end else if (clr_ovr) begin
            r_ovr <= 1'b0;
        end
    end

    assign data_out = r_data;
    assign valid    = r_valid;
    assign busy     = (r_state == SHIFT);
    assign overrun  = r_ovr;

endmodule : shift_capture

`default_nettype wire

// File: tb/tb_shift_capture.sv
// ============================================================================
// Module      : tb_shift_capture
// Description : Directed self-checking bench for shift_capture (WIDTH=5)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_capture;

    localparam int WIDTH = 5;

    logic             clock;
    logic             reset;
    logic             start;
    logic             dir;
    logic             sample_en;
    logic             sdata;
    logic             ready;
    logic             clr_ovr;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             busy;
    logic             overrun;

    int total = 0;
    int bad   = 0;

    shift_capture #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .dir      (dir),
        .sample_en(sample_en),
        .sdata    (sdata),
        .ready    (ready),
        .clr_ovr  (clr_ovr),
        .data_out (data_out),
        .valid    (valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are checked there too
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic d, input logic se, input logic sd);
        start = 1'b1; dir = d; sample_en = se; sdata = sd;
        tick();
        start = 1'b0; sample_en = 1'b0; sdata = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        sample_en = 1'b1; sdata = b;
        tick();
        sample_en = 1'b0; sdata = 1'b0;
    endtask

    task automatic send_bits(input logic [4:0] bits, input int n);
        for (int i = 0; i < n; i++) send_bit(bits[4-i]);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; dir = 1'b0; sample_en = 1'b0;
        sdata = 1'b0; ready = 1'b0; clr_ovr = 1'b0;
        #12;
        chk("rst_data",  32'(data_out), 32'h00);
        chk("rst_valid", 32'(valid),    32'h0);
        chk("rst_busy",  32'(busy),     32'h0);
        chk("rst_ovr",   32'(overrun),  32'h0);
        tick();
        reset = 1'b1;
        tick();

        // Strobes while idle must not start or alter anything
        send_bits(5'b11111, 5);
        chk("idle_busy",  32'(busy),  32'h0);
        chk("idle_valid", 32'(valid), 32'h0);

        // Test 1: MSB-first
        do_start(1'b0, 1'b0, 1'b0);
        chk("t1_busy_start", 32'(busy), 32'h1);
        send_bits(5'b10110, 4);
        chk("t1_valid_mid", 32'(valid), 32'h0);
        send_bit(1'b0);
        chk("t1_data",  32'(data_out), 32'h16);
        chk("t1_valid", 32'(valid),    32'h1);
        chk("t1_busy",  32'(busy),     32'h0);
        chk("t1_ovr",   32'(overrun),  32'h0);

        // Test 3: overrun while ready held low, then clear
        do_start(1'b0, 1'b0, 1'b0);
        send_bits(5'b00001, 5);
        chk("t3_ovr",   32'(overrun),  32'h1);
        chk("t3_data",  32'(data_out), 32'h16);
        chk("t3_valid", 32'(valid),    32'h1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("t3_clr", 32'(overrun), 32'h0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("t3_consume", 32'(valid), 32'h0);

        // Test 2: LSB-first
        do_start(1'b1, 1'b0, 1'b0);
        send_bits(5'b10110, 5);
        chk("t2_data",  32'(data_out), 32'h0D);
        chk("t2_valid", 32'(valid),    32'h1);

        // Test 4: completion coincides with consumption of the previous word
        do_start(1'b0, 1'b0, 1'b0);
        send_bits(5'b00011, 4);
        chk("t4_hold", 32'(data_out), 32'h0D);
        ready = 1'b1;
        send_bit(1'b1);
        ready = 1'b0;
        chk("t4_data",  32'(data_out), 32'h03);
        chk("t4_valid", 32'(valid),    32'h1);
        chk("t4_ovr",   32'(overrun),  32'h0);
        ready = 1'b1;
        tick();
        ready = 1'b0;

        // Test 5: restart mid-frame; the strobe on the start cycle is ignored
        do_start(1'b1, 1'b0, 1'b0);
        send_bits(5'b11100, 3);
        do_start(1'b0, 1'b1, 1'b1);
        chk("t5_busy", 32'(busy), 32'h1);
        send_bits(5'b11001, 5);
        chk("t5_data",  32'(data_out), 32'h19);
        chk("t5_valid", 32'(valid),    32'h1);

        // Test 6: overrun, then asynchronous reset in the middle of a frame
        do_start(1'b0, 1'b0, 1'b0);
        send_bits(5'b01010, 5);
        chk("t6_ovr_set", 32'(overrun), 32'h1);
        do_start(1'b0, 1'b0, 1'b0);
        send_bits(5'b11000, 2);
        chk("t6_busy_pre", 32'(busy), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_data",  32'(data_out), 32'h00);
        chk("t6_valid", 32'(valid),    32'h0);
        chk("t6_busy",  32'(busy),     32'h0);
        chk("t6_ovr",   32'(overrun),  32'h0);
        tick();
        reset = 1'b1;
        tick();
        send_bits(5'b11111, 3);
        chk("t6_idle_after", 32'(busy), 32'h0);
        do_start(1'b0, 1'b0, 1'b0);
        send_bits(5'b10000, 5);
        chk("t6_new_data",  32'(data_out), 32'h10);
        chk("t6_new_valid", 32'(valid),    32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_shift_capture

`default_nettype wire
